alu_issue_queue: RTL and testbench

ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

---
 rtl/alu_issue_queue_pkg.sv | 52 +++++
 rtl/alu_issue_queue_iq_select2.sv | 34 +++
 rtl/alu_issue_queue.sv | 157 +++++++++++++++
 tb/tb_alu_issue_queue.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_queue_pkg.sv
// Shared definitions for the ALU issue queue.
//   UOPBundle  : micro-op as seen by dispatch and the ALUs (.valid marks a live uop)
//   PRFwInfo   : physical register file writeback (wen, rd, data)
//   iq_entry_t : one issue queue slot (valid, uop, per-source ready bits)
//   tag_hit    : true when a source tag matches any valid wakeup tag
package alu_issue_queue_pkg;

  localparam int PRF_AW   = 6;
  localparam int IQ_DEPTH = 8;
  localparam int N_TAGS   = 4;  // two grant destinations + two external writebacks

  typedef struct packed {
    logic              valid;
    logic [3:0]        aluop;
    logic              op0re;
    logic [PRF_AW-1:0] op0PAddr;
    logic              op1re;
    logic [PRF_AW-1:0] op1PAddr;
    logic              dstwe;
    logic [PRF_AW-1:0] dstPAddr;
    logic [5:0]        robIdx;
    logic [7:0]        imm;
  } UOPBundle;

  typedef struct packed {
    logic              wen;
    logic [PRF_AW-1:0] rd;
    logic [31:0]       data;
  } PRFwInfo;

  localparam int UOP_W  = $bits(UOPBundle);
  localparam int PRFW_W = $bits(PRFwInfo);

  typedef struct packed {
    logic     valid;
    UOPBundle uop;
    logic     r0;
    logic     r1;
  } iq_entry_t;

  function automatic logic tag_hit(input logic [PRF_AW-1:0]             src,
                                   input logic [N_TAGS-1:0]             tag_v,
                                   input logic [N_TAGS-1:0][PRF_AW-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < N_TAGS; k++) begin
      if (tag_v[k] && (tags[k] == src)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/alu_issue_queue_iq_select2.sv
// Two-way oldest-first picker.
//   req        : DEPTH-bit request vector, bit 0 is the oldest entry
//   gnt0_valid : a request exists; gnt0_idx is the lowest set index
//   gnt1_valid : a second request exists; gnt1_idx is the second-lowest
module iq_select2 #(
  parameter int DEPTH = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] req,
  output logic             gnt0_valid,
  output logic [IDX_W-1:0] gnt0_idx,
  output logic             gnt1_valid,
  output logic [IDX_W-1:0] gnt1_idx
);

  always_comb begin
    gnt0_valid = 1'b0;
    gnt0_idx   = '0;
    gnt1_valid = 1'b0;
    gnt1_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (req[i]) begin
        if (!gnt0_valid) begin
          gnt0_valid = 1'b1;
          gnt0_idx   = IDX_W'(i);
        end else if (!gnt1_valid) begin
          gnt1_valid = 1'b1;
          gnt1_idx   = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/alu_issue_queue.sv
// Compacting, oldest-first issue queue feeding two ALUs.
//   clk, rst_n            : clock (rising edge) and asynchronous active-low reset
//   flush                 : discard all entries and the issue selected this cycle
//   enq_valid/enq_uop     : dispatch offer, with busy-table readiness enq_op0rdy/enq_op1rdy
//   enq_ready             : room for one more uop (registered count only)
//   ext_wake0/ext_wake1   : non-ALU writebacks, only wen and rd matter here
//   issue0_uop/issue1_uop : registered grants to ALU0/ALU1, .valid marks an issue
//
// Enqueue handshake: a uop transfers on a rising edge where enq_valid && enq_ready
// && !flush; enq_ready does not depend on enq_valid or on same-cycle issue.
module alu_issue_queue
  import alu_issue_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              enq_valid,
  input  logic [UOP_W-1:0]  enq_uop,
  input  logic              enq_op0rdy,
  input  logic              enq_op1rdy,
  output logic              enq_ready,
  input  logic [PRFW_W-1:0] ext_wake0,
  input  logic [PRFW_W-1:0] ext_wake1,
  output logic [UOP_W-1:0]  issue0_uop,
  output logic [UOP_W-1:0]  issue1_uop
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  iq_entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [CNT_W-1:0]      count_q, count_d;
  UOPBundle              issue0_q, issue0_d;
  UOPBundle              issue1_q, issue1_d;

  UOPBundle enq_u;
  PRFwInfo  wake0, wake1;
  logic     unused_wake_data;

  assign enq_u = enq_uop;
  assign wake0 = ext_wake0;
  assign wake1 = ext_wake1;
  assign unused_wake_data = ^{wake0.data, wake1.data};

  logic [DEPTH-1:0] req;
  logic             gnt0_valid, gnt1_valid;
  logic [IDX_W-1:0] gnt0_idx, gnt1_idx;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      req[i] = entries_q[i].valid & entries_q[i].r0 & entries_q[i].r1;
    end
  end

  iq_select2 #(.DEPTH(DEPTH)) u_select (
    .req        (req),
    .gnt0_valid (gnt0_valid),
    .gnt0_idx   (gnt0_idx),
    .gnt1_valid (gnt1_valid),
    .gnt1_idx   (gnt1_idx)
  );

  assign enq_ready = (count_q < DEPTH_C);

  // Wakeup tags broadcast this cycle; grant destinations let dependents issue
  // back-to-back through the ALU bypass.
  logic [N_TAGS-1:0]             tag_v;
  logic [N_TAGS-1:0][PRF_AW-1:0] tags;

  always_comb begin
    tag_v[0] = gnt0_valid & entries_q[gnt0_idx].uop.dstwe;
    tags[0]  = entries_q[gnt0_idx].uop.dstPAddr;
    tag_v[1] = gnt1_valid & entries_q[gnt1_idx].uop.dstwe;
    tags[1]  = entries_q[gnt1_idx].uop.dstPAddr;
    tag_v[2] = wake0.wen;
    tags[2]  = wake0.rd;
    tag_v[3] = wake1.wen;
    tags[3]  = wake1.rd;
  end

  logic enq_fire;
  assign enq_fire = enq_valid & enq_ready & ~flush;

  always_comb begin
    iq_entry_t        ent;
    logic [CNT_W-1:0] wr_ptr;
    logic             granted;

    ent        = '0;
    wr_ptr     = '0;
    granted    = 1'b0;
    entries_d  = '0;
    issue0_d   = '0;
    issue1_d   = '0;

    // Survivors shift down in order; wr_ptr ends as count minus grants.
    for (int i = 0; i < DEPTH; i++) begin
      granted = (gnt0_valid && (gnt0_idx == IDX_W'(i))) ||
                (gnt1_valid && (gnt1_idx == IDX_W'(i)));
      if (entries_q[i].valid && !granted) begin
        ent    = entries_q[i];
        ent.r0 = ent.r0 | tag_hit(ent.uop.op0PAddr, tag_v, tags);
        ent.r1 = ent.r1 | tag_hit(ent.uop.op1PAddr, tag_v, tags);
        entries_d[wr_ptr[IDX_W-1:0]] = ent;
        wr_ptr = wr_ptr + CNT_W'(1);
      end
    end

    // enq_ready guarantees wr_ptr < DEPTH here.
    if (enq_fire) begin
      ent       = '0;
      ent.valid = 1'b1;
      ent.uop   = enq_u;
      ent.r0    = ~enq_u.op0re | enq_op0rdy | tag_hit(enq_u.op0PAddr, tag_v, tags);
      ent.r1    = ~enq_u.op1re | enq_op1rdy | tag_hit(enq_u.op1PAddr, tag_v, tags);
      entries_d[wr_ptr[IDX_W-1:0]] = ent;
    end
    count_d = wr_ptr + CNT_W'(enq_fire);

    if (gnt0_valid) begin
      issue0_d       = entries_q[gnt0_idx].uop;
      issue0_d.valid = 1'b1;
    end
    if (gnt1_valid) begin
      issue1_d       = entries_q[gnt1_idx].uop;
      issue1_d.valid = 1'b1;
    end

    if (flush) begin
      entries_d = '0;
      count_d   = '0;
      issue0_d  = '0;
      issue1_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries_q <= '0;
      count_q   <= '0;
      issue0_q  <= '0;
      issue1_q  <= '0;
    end else begin
      entries_q <= entries_d;
      count_q   <= count_d;
      issue0_q  <= issue0_d;
      issue1_q  <= issue1_d;
    end
  end

  assign issue0_uop = issue0_q;
  assign issue1_uop = issue1_q;

endmodule

// File: tb/tb_alu_issue_queue.sv
module tb_alu_issue_queue;
  import alu_issue_queue_pkg::*;

  localparam int DEPTH = 8;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic              flush, enq_valid, enq_op0rdy, enq_op1rdy, enq_ready;
  UOPBundle          enq_s;
  PRFwInfo           w0_s, w1_s;
  logic [UOP_W-1:0]  enq_uop, issue0_uop, issue1_uop;
  logic [PRFW_W-1:0] ext_wake0, ext_wake1;
  UOPBundle          iss0, iss1;

  assign enq_uop   = enq_s;
  assign ext_wake0 = w0_s;
  assign ext_wake1 = w1_s;
  assign iss0      = issue0_uop;
  assign iss1      = issue1_uop;

  alu_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .enq_valid  (enq_valid),
    .enq_uop    (enq_uop),
    .enq_op0rdy (enq_op0rdy),
    .enq_op1rdy (enq_op1rdy),
    .enq_ready  (enq_ready),
    .ext_wake0  (ext_wake0),
    .ext_wake1  (ext_wake1),
    .issue0_uop (issue0_uop),
    .issue1_uop (issue1_uop)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    UOPBundle uop;
    logic     r0;
    logic     r1;
  } m_ent_t;

  m_ent_t   mq[$];        // oldest at index 0
  UOPBundle exp_i0, exp_i1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic check_uop(input string name, input UOPBundle act, input UOPBundle exp);
    if (exp.valid) check(name, 64'(act), 64'(exp));
    else check({name, ".valid"}, 64'(act.valid), 64'd0);
  endtask

  task automatic model_reset();
    mq.delete();
    exp_i0 = '0;
    exp_i1 = '0;
  endtask

  // One clock edge of the queue, from the behavioural rules.
  task automatic model_step();
    int               g0, g1;
    logic             fire;
    m_ent_t           ne;
    logic [PRF_AW-1:0] tg[$];
    if (flush) begin
      model_reset();
      return;
    end
    g0 = -1;
    g1 = -1;
    foreach (mq[i]) begin
      if (mq[i].r0 && mq[i].r1) begin
        if (g0 < 0) g0 = i;
        else if (g1 < 0) g1 = i;
      end
    end
    exp_i0 = '0;
    exp_i1 = '0;
    if (g0 >= 0) begin
      exp_i0 = mq[g0].uop;
      exp_i0.valid = 1'b1;
      if (mq[g0].uop.dstwe) tg.push_back(mq[g0].uop.dstPAddr);
    end
    if (g1 >= 0) begin
      exp_i1 = mq[g1].uop;
      exp_i1.valid = 1'b1;
      if (mq[g1].uop.dstwe) tg.push_back(mq[g1].uop.dstPAddr);
    end
    if (w0_s.wen) tg.push_back(w0_s.rd);
    if (w1_s.wen) tg.push_back(w1_s.rd);
    fire = enq_valid && (mq.size() < DEPTH);
    if (g1 >= 0) mq.delete(g1);
    if (g0 >= 0) mq.delete(g0);
    foreach (mq[i]) begin
      ne = mq[i];
      foreach (tg[k]) begin
        if (ne.uop.op0PAddr == tg[k]) ne.r0 = 1'b1;
        if (ne.uop.op1PAddr == tg[k]) ne.r1 = 1'b1;
      end
      mq[i] = ne;
    end
    if (fire) begin
      ne.uop = enq_s;
      ne.r0  = !enq_s.op0re || enq_op0rdy;
      ne.r1  = !enq_s.op1re || enq_op1rdy;
      foreach (tg[k]) begin
        if (enq_s.op0PAddr == tg[k]) ne.r0 = 1'b1;
        if (enq_s.op1PAddr == tg[k]) ne.r1 = 1'b1;
      end
      mq.push_back(ne);
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic UOPBundle mk_uop(input logic [5:0] rob, input logic op0re,
                                      input logic [5:0] op0p, input logic op1re,
                                      input logic [5:0] op1p, input logic dstwe,
                                      input logic [5:0] dst);
    UOPBundle u;
    u          = '0;
    u.valid    = 1'b1;
    u.aluop    = rob[3:0];
    u.op0re    = op0re;
    u.op0PAddr = op0p;
    u.op1re    = op1re;
    u.op1PAddr = op1p;
    u.dstwe    = dstwe;
    u.dstPAddr = dst;
    u.robIdx   = rob;
    u.imm      = {rob, 2'b10};
    return u;
  endfunction

  task automatic idle_inputs();
    flush      = 1'b0;
    enq_valid  = 1'b0;
    enq_s      = '0;
    enq_op0rdy = 1'b0;
    enq_op1rdy = 1'b0;
    w0_s       = '0;
    w1_s       = '0;
  endtask

  // Outputs are compared one time unit after the previous rising edge.
  task automatic step(input string tag);
    check(   {tag, " enq_ready"}, 64'(enq_ready), 64'(mq.size() < DEPTH));
    check_uop({tag, " issue0"}, iss0, exp_i0);
    check_uop({tag, " issue1"}, iss1, exp_i1);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic enq_one(input UOPBundle u, input logic r0, input logic r1);
    idle_inputs();
    enq_valid  = 1'b1;
    enq_s      = u;
    enq_op0rdy = r0;
    enq_op1rdy = r1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       enq_valid;
    logic [5:0] rob;
    logic       op0re;  logic [5:0] op0p; logic op0rdy;
    logic       op1re;  logic [5:0] op1p; logic op1rdy;
    logic       dstwe;  logic [5:0] dst;
    logic       w0en;   logic [5:0] w0rd;
    logic       w1en;   logic [5:0] w1rd;
    logic       exp_rdy;
    logic       exp_v0; logic [5:0] exp_r0;
    logic       exp_v1; logic [5:0] exp_r1;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs[NVEC];

  function automatic vec_t v(input logic ev, input logic [5:0] rob,
                             input logic a0re, input logic [5:0] a0p, input logic a0rdy,
                             input logic a1re, input logic [5:0] a1p, input logic a1rdy,
                             input logic dwe, input logic [5:0] dst,
                             input logic x0, input logic [5:0] x0rd,
                             input logic x1, input logic [5:0] x1rd,
                             input logic erdy, input logic ev0, input logic [5:0] er0,
                             input logic ev1, input logic [5:0] er1);
    vec_t r;
    r.enq_valid = ev;   r.rob = rob;
    r.op0re = a0re;     r.op0p = a0p;  r.op0rdy = a0rdy;
    r.op1re = a1re;     r.op1p = a1p;  r.op1rdy = a1rdy;
    r.dstwe = dwe;      r.dst = dst;
    r.w0en = x0;        r.w0rd = x0rd;
    r.w1en = x1;        r.w1rd = x1rd;
    r.exp_rdy = erdy;   r.exp_v0 = ev0; r.exp_r0 = er0;
    r.exp_v1 = ev1;     r.exp_r1 = er1;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Producer A then dependent B: A issues at cycle 2, B at cycle 3.
    vecs[0]  = v(1, 6'd1, 1, 6'd10, 1, 0, 6'd0, 0, 1, 6'd5, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[1]  = v(1, 6'd2, 1, 6'd5,  0, 0, 6'd0, 0, 1, 6'd6, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[2]  = v(0, 6'd0, 0, 6'd0,  0, 0, 6'd0, 0, 0, 6'd0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    vecs[3]  = v(0, 6'd0, 0, 6'd0,  0, 0, 6'd0, 0, 0, 6'd0, 0, 0, 0, 0, 1, 1, 2, 0, 0);
    vecs[4]  = v(0, 6'd0, 0, 6'd0,  0, 0, 6'd0, 0, 0, 6'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    // Three entries woken together: two issue, the third follows on ALU0.
    vecs[5]  = v(1, 6'd3, 1, 6'd20, 0, 0, 6'd0, 0, 0, 6'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[6]  = v(1, 6'd4, 1, 6'd20, 0, 0, 6'd0, 0, 0, 6'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[7]  = v(1, 6'd5, 1, 6'd20, 0, 0, 6'd0, 0, 0, 6'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[8]  = v(0, 6'd0, 0, 6'd0,  0, 0, 6'd0, 0, 0, 6'd0, 1, 20, 0, 0, 1, 0, 0, 0, 0);
    vecs[9]  = v(0, 6'd0, 0, 6'd0,  0, 0, 6'd0, 0, 0, 6'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[10] = v(0, 6'd0, 0, 6'd0,  0, 0, 6'd0, 0, 0, 6'd0, 0, 0, 0, 0, 1, 1, 3, 1, 4);
    vecs[11] = v(0, 6'd0, 0, 6'd0,  0, 0, 6'd0, 0, 0, 6'd0, 0, 0, 0, 0, 1, 1, 5, 0, 0);
    vecs[12] = v(0, 6'd0, 0, 6'd0,  0, 0, 6'd0, 0, 0, 6'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    // op1 tag woken by ext_wake1 in the enqueue cycle.
    vecs[13] = v(1, 6'd6, 0, 6'd0,  0, 1, 6'd30, 0, 0, 6'd0, 0, 0, 1, 30, 1, 0, 0, 0, 0);
    vecs[14] = v(0, 6'd0, 0, 6'd0,  0, 0, 6'd0, 0, 0, 6'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    vecs[15] = v(0, 6'd0, 0, 6'd0,  0, 0, 6'd0, 0, 0, 6'd0, 0, 0, 0, 0, 1, 1, 6, 0, 0);
    vecs[16] = v(0, 6'd0, 0, 6'd0,  0, 0, 6'd0, 0, 0, 6'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

    // ---- reset ----
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #12;
    check("reset enq_ready", 64'(enq_ready), 64'd1);
    check("reset issue0.valid", 64'(iss0.valid), 64'd0);
    check("reset issue1.valid", 64'(iss1.valid), 64'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    model_step();
    #1;

    // ---- table-driven directed vectors ----
    for (int n = 0; n < NVEC; n++) begin
      idle_inputs();
      enq_valid  = vecs[n].enq_valid;
      if (vecs[n].enq_valid)
        enq_s = mk_uop(vecs[n].rob, vecs[n].op0re, vecs[n].op0p, vecs[n].op1re,
                       vecs[n].op1p, vecs[n].dstwe, vecs[n].dst);
      enq_op0rdy = vecs[n].op0rdy;
      enq_op1rdy = vecs[n].op1rdy;
      w0_s.wen   = vecs[n].w0en;
      w0_s.rd    = vecs[n].w0rd;
      w1_s.wen   = vecs[n].w1en;
      w1_s.rd    = vecs[n].w1rd;
      check($sformatf("vec%0d enq_ready", n), 64'(enq_ready), 64'(vecs[n].exp_rdy));
      check($sformatf("vec%0d issue0.valid", n), 64'(iss0.valid), 64'(vecs[n].exp_v0));
      check($sformatf("vec%0d issue1.valid", n), 64'(iss1.valid), 64'(vecs[n].exp_v1));
      if (vecs[n].exp_v0) check($sformatf("vec%0d issue0.rob", n), 64'(iss0.robIdx), 64'(vecs[n].exp_r0));
      if (vecs[n].exp_v1) check($sformatf("vec%0d issue1.rob", n), 64'(iss1.robIdx), 64'(vecs[n].exp_r1));
      step($sformatf("vec%0d", n));
    end

    // ---- full queue, wake entries 0 and 3 ----
    for (int k = 0; k < DEPTH; k++) begin
      enq_one(mk_uop(6'(16 + k), 1, ((k == 0) || (k == 3)) ? 6'd40 : 6'd41, 0, 6'd0, 0, 6'd0), 0, 0);
      step("fill");
    end
    idle_inputs();
    check("full enq_ready", 64'(enq_ready), 64'd0);
    w0_s.wen = 1'b1;
    w0_s.rd  = 6'd40;
    step("full wake");
    enq_one(mk_uop(6'd63, 0, 6'd0, 0, 6'd0, 0, 6'd0), 1, 1);
    check("full+issue enq_ready", 64'(enq_ready), 64'd0);
    step("full offer");
    idle_inputs();
    check("woken issue0.valid", 64'(iss0.valid), 64'd1);
    check("woken issue0.rob", 64'(iss0.robIdx), 64'd16);
    check("woken issue1.valid", 64'(iss1.valid), 64'd1);
    check("woken issue1.rob", 64'(iss1.robIdx), 64'd19);
    check("after full enq_ready", 64'(enq_ready), 64'd1);
    w0_s.wen = 1'b1;
    w0_s.rd  = 6'd41;
    step("drain wake");
    idle_inputs();
    for (int k = 0; k < 5; k++) step("drain");

    // ---- flush with five entries and a pending issue ----
    for (int k = 0; k < 5; k++) begin
      enq_one(mk_uop(6'(32 + k), 1, 6'd50, 0, 6'd0, 0, 6'd0), 0, 0);
      step("pre-flush fill");
    end
    idle_inputs();
    w0_s.wen = 1'b1;
    w0_s.rd  = 6'd50;
    step("pre-flush wake");
    enq_one(mk_uop(6'd40, 0, 6'd0, 0, 6'd0, 0, 6'd0), 1, 1);
    flush = 1'b1;
    step("flush");
    idle_inputs();
    check("post-flush enq_ready", 64'(enq_ready), 64'd1);
    check("post-flush issue0.valid", 64'(iss0.valid), 64'd0);
    check("post-flush issue1.valid", 64'(iss1.valid), 64'd0);
    step("post-flush");
    step("post-flush");
    check("flushed enq dropped", 64'(iss0.valid), 64'd0);

    // ---- asynchronous reset mid-stream ----
    for (int k = 0; k < 3; k++) begin
      enq_one(mk_uop(6'(44 + k), 0, 6'd0, 0, 6'd0, 1, 6'(8 + k)), 1, 1);
      step("pre-reset");
    end
    idle_inputs();
    check("pre-reset issue0.valid", 64'(iss0.valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset issue0.valid", 64'(iss0.valid), 64'd0);
    check("async reset issue1.valid", 64'(iss1.valid), 64'd0);
    check("async reset enq_ready", 64'(enq_ready), 64'd1);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    model_step();
    #1;
    for (int k = 0; k < 3; k++) step("post-reset");

    // ---- randomized traffic against the reference model ----
    for (int c = 0; c < 400; c++) begin
      idle_inputs();
      flush      = ($urandom_range(0, 39) == 0);
      enq_valid  = ($urandom_range(0, 3) != 0);
      enq_s      = UOPBundle'({$urandom(), $urandom()});
      enq_s.op0PAddr = 6'($urandom_range(0, 7));
      enq_s.op1PAddr = 6'($urandom_range(0, 7));
      enq_s.dstPAddr = 6'($urandom_range(0, 7));
      enq_op0rdy = ($urandom_range(0, 3) == 0);
      enq_op1rdy = ($urandom_range(0, 3) == 0);
      w0_s       = PRFwInfo'({$urandom(), $urandom()});
      w0_s.wen   = ($urandom_range(0, 3) == 0);
      w0_s.rd    = 6'($urandom_range(0, 7));
      w1_s       = PRFwInfo'({$urandom(), $urandom()});
      w1_s.wen   = ($urandom_range(0, 4) == 0);
      w1_s.rd    = 6'($urandom_range(0, 7));
      step("rand");
    end
    idle_inputs();
    for (int k = 0; k < 8; k++) step("rand drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
